// File: rtl/program_loader_if.sv
// Bundles the loader's byte stream, CPU write port and RAM write port.
interface program_loader_if #(parameter int unsigned SIZE = 10);
    logic            in_valid;
    logic [7:0]      in_data;
    logic            in_ready;
    logic            cpu_rst;
    logic            cpu_wrEn;
    logic [SIZE-1:0] cpu_addr;
    logic [31:0]     cpu_data;
    logic            ram_wrEn;
    logic [SIZE-1:0] ram_addr;
    logic [31:0]     ram_data;
    logic            done;
    logic            err;

    modport slave (
        input  in_valid, in_data, cpu_wrEn, cpu_addr, cpu_data,
        output in_ready, cpu_rst, ram_wrEn, ram_addr, ram_data, done, err
    );

    modport master (
        output in_valid, in_data, cpu_wrEn, cpu_addr, cpu_data,
        input  in_ready, cpu_rst, ram_wrEn, ram_addr, ram_data, done, err
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: receives a checksummed word image over a byte stream, writes it to RAM
// from address 0, then releases the CPU and hands it the RAM write port.
module program_loader #(
    parameter int unsigned SIZE = 10
) (
    input logic             clk,
    input logic             rst,
    program_loader_if.slave bus
);
    localparam int unsigned CAP = 1 << SIZE;

    typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, RUN, ERR} state_t;

    state_t          state_q, state_d;
    logic [7:0]      n_lo;
    logic [15:0]     n;
    logic [15:0]     n_in;
    logic [1:0]      cnt;
    logic [SIZE:0]   w;
    logic [7:0]      xacc;
    logic [23:0]     buf_q;
    logic            wr_q;
    logic [SIZE-1:0] addr_q;
    logic [31:0]     data_q;
    logic            loading;
    logic            take;

    assign n_in = {bus.in_data, n_lo};
    assign take = bus.in_valid && loading;

    always_ff @(posedge clk) begin
        if (rst) state_q <= HDR0;
        else     state_q <= state_d;
    end

    // Next state plus state-decoded outputs; RUN hands the RAM port to the CPU.
    always_comb begin
        state_d      = state_q;
        loading      = 1'b0;
        bus.in_ready = 1'b0;
        bus.cpu_rst  = 1'b1;
        bus.done     = 1'b0;
        bus.err      = 1'b0;
        bus.ram_wrEn = wr_q;
        bus.ram_addr = addr_q;
        bus.ram_data = data_q;
        case (state_q)
            HDR0: begin
                loading = 1'b1;
                if (take) state_d = HDR1;
            end
            HDR1: begin
                loading = 1'b1;
                if (take) begin
                    if (32'(n_in) > CAP)   state_d = ERR;
                    else if (n_in == 16'd0) state_d = CSUM;
                    else                    state_d = DATA;
                end
            end
            DATA: begin
                loading = 1'b1;
                if (take && cnt == 2'd3 && (32'(w) + 32'd1 == 32'(n))) state_d = CSUM;
            end
            CSUM: begin
                loading = 1'b1;
                if (take) state_d = (bus.in_data == xacc) ? RUN : ERR;
            end
            RUN: begin
                bus.cpu_rst  = 1'b0;
                bus.done     = 1'b1;
                bus.ram_wrEn = bus.cpu_wrEn;
                bus.ram_addr = bus.cpu_addr;
                bus.ram_data = bus.cpu_data;
            end
            ERR: bus.err = 1'b1;
            default: state_d = HDR0;
        endcase
        bus.in_ready = loading;
    end

    // Header capture, word assembly, checksum and the one-cycle load write.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_lo   <= '0;
            n      <= '0;
            cnt    <= '0;
            w      <= '0;
            xacc   <= '0;
            buf_q  <= '0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            if (take) begin
                case (state_q)
                    HDR0: n_lo <= bus.in_data;
                    HDR1: n    <= n_in;
                    DATA: begin
                        xacc <= xacc ^ bus.in_data;
                        cnt  <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            wr_q   <= 1'b1;
                            addr_q <= w[SIZE-1:0];
                            data_q <= {bus.in_data, buf_q};
                            w      <= w + (SIZE+1)'(1);
                        end else begin
                            buf_q <= {bus.in_data, buf_q[23:8]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
